// File: rtl/circle_raster.sv
// circle_raster: Bresenham circle rasteriser streaming clipped points or filled spans over valid/ready
// Ports: clk, n_rst (async active-low); start/abort control; fill/cx/cy/radius latched at start;
//        px_valid/px_ready handshake carrying px_x0..px_x1 on row px_y; busy while drawing, done pulse at end.
module circle_raster #(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int RW    = 10,
  parameter int SCR_W = 640,
  parameter int SCR_H = 480
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          abort,
  input  logic          fill,
  input  logic [XW-1:0] cx,
  input  logic [YW-1:0] cy,
  input  logic [RW-1:0] radius,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [XW-1:0] px_x0,
  output logic [XW-1:0] px_x1,
  output logic [YW-1:0] px_y,
  output logic          busy,
  output logic          done
);
  localparam int MW = XW > YW ? (XW > RW ? XW : RW) : (YW > RW ? YW : RW);
  localparam int CW = MW + 2;
  localparam int DW = RW + 4;
  localparam logic [2:0] IDLE = 3'd0, CHECK = 3'd1, EMIT = 3'd2, UPDATE = 3'd3, FINISH = 3'd4;
  localparam logic signed [CW-1:0] SW  = CW'(SCR_W);
  localparam logic signed [CW-1:0] SWM = CW'(SCR_W - 1);
  localparam logic signed [CW-1:0] SH  = CW'(SCR_H);
  logic [2:0] state, k;
  logic fill_r;
  logic signed [CW-1:0] ccx, ccy, x, y, u, v, xl, xr, row, xlc, xrc;
  logic signed [DW-1:0] d;
  logic swap, xneg, yneg, clip, emit, last, dle;
  // Octant selection from k: swap exchanges x/y roles, xneg/yneg mirror about the centre.
  // Fill spans are always centre-symmetric in x, so only swap and the row sign matter.
  assign swap = k[0] ^ k[1];
  assign xneg = fill_r ? 1'b0 : k[1] ^ k[2];
  assign yneg = fill_r ? k[1] : k[2];
  assign u    = swap ? y : x;
  assign v    = swap ? x : y;
  assign xl   = (fill_r || xneg) ? ccx - u : ccx + u;
  assign xr   = (fill_r || !xneg) ? ccx + u : ccx - u;
  assign row  = yneg ? ccy - v : ccy + v;
  // A point is a degenerate span, so one clip test serves both modes.
  assign clip = xr[CW-1] || xl >= SW || row[CW-1] || row >= SH;
  assign xlc  = xl[CW-1] ? '0 : xl;
  assign xrc  = xr >= SW ? SWM : xr;
  assign emit = state == EMIT;
  assign last = k == (fill_r ? 3'd3 : 3'd7);
  assign dle  = d[DW-1] || d == '0;
  assign px_valid = emit && !clip && !abort;
  assign px_x0    = emit ? XW'(xlc) : '0;
  assign px_x1    = emit ? XW'(xrc) : '0;
  assign px_y     = emit ? YW'(row) : '0;
  assign busy     = state == CHECK || state == EMIT || state == UPDATE;
  assign done     = state == FINISH && !abort;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state  <= IDLE;
      k      <= '0;
      fill_r <= 1'b0;
      ccx    <= '0;
      ccy    <= '0;
      x      <= '0;
      y      <= '0;
      d      <= '0;
    end else if (abort) state <= IDLE;
    else
      case (state)
        IDLE: if (start) begin
          fill_r <= fill;
          ccx    <= CW'(cx);
          ccy    <= CW'(cy);
          x      <= '0;
          y      <= CW'(radius);
          d      <= DW'(3) - (DW'(radius) <<< 1);
          k      <= '0;
          state  <= CHECK;
        end
        CHECK: begin
          k     <= '0;
          state <= (x <= y) ? EMIT : FINISH;
        end
        EMIT: if (clip || px_ready) begin
          k <= k + 3'd1;
          if (last) state <= UPDATE;
        end
        UPDATE: begin
          d     <= dle ? d + (DW'(x) <<< 2) + DW'(6) : d + ((DW'(x) - DW'(y)) <<< 2) + DW'(10);
          y     <= dle ? y : y - CW'(1);
          x     <= x + CW'(1);
          state <= CHECK;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_circle_raster.sv
// tb_circle_raster: directed bench for circle_raster with hand-computed beat lists
module tb_circle_raster;
  logic clk = 0, n_rst = 0, start = 0, abort = 0, fill = 0;
  logic [9:0] cx = 0, radius = 0, px_x0, px_x1;
  logic [8:0] cy = 0, px_y;
  logic px_valid, px_ready, busy, done;
  logic ready_fix = 1, rnd_en = 0, rnd_bit = 1, held = 0;
  logic [28:0] hold_val = 0;
  int errors = 0, checks = 0;
  int gx0[$], gx1[$], gy[$], ex0[$], ex1[$], ey[$];
  int done_cnt = 0, stab_bad = 0, stalls = 0, first_v = 0, busy_bad = 0, d0 = 0, base = 0;

  assign px_ready = rnd_en ? rnd_bit : ready_fix;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  circle_raster dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .fill(fill),
    .cx(cx), .cy(cy), .radius(radius), .px_valid(px_valid), .px_ready(px_ready),
    .px_x0(px_x0), .px_x1(px_x1), .px_y(px_y), .busy(busy), .done(done)
  );

  always @(negedge clk) begin
    if (px_valid && px_ready) begin
      gx0.push_back(int'(px_x0));
      gx1.push_back(int'(px_x1));
      gy.push_back(int'(px_y));
    end
    if (done) done_cnt++;
    if (held && px_valid) begin
      stalls++;
      if ({px_x0, px_x1, px_y} != hold_val) stab_bad++;
    end
    if (held && !px_valid && !abort && n_rst) stab_bad++;
    held = px_valid && !px_ready;
    hold_val = {px_x0, px_x1, px_y};
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic s(input int x0, input int x1, input int y);
    ex0.push_back(x0);
    ex1.push_back(x1);
    ey.push_back(y);
  endtask

  task automatic o(input int x, input int y);
    s(x, x, y);
  endtask

  task automatic run(input string tag, input int x, input int y, input int r, input bit f);
    int b;
    b = gx0.size();
    first_v = 0;
    busy_bad = 0;
    @(posedge clk);
    #1 cx = 10'(x); cy = 9'(y); radius = 10'(r); fill = f; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (px_valid && first_v == 0) first_v = c;
      if (done) break;
      if (!busy) busy_bad++;
    end
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " busy"}, busy_bad, 0);
    chk({tag, " beats"}, gx0.size() - b, ex0.size());
    for (int i = 0; i < ex0.size() && b + i < gx0.size(); i++) begin
      chk($sformatf("%s x0[%0d]", tag, i), gx0[b+i], ex0[i]);
      chk($sformatf("%s x1[%0d]", tag, i), gx1[b+i], ex1[i]);
      chk($sformatf("%s y[%0d]", tag, i), gy[b+i], ey[i]);
    end
    @(negedge clk);
    chk({tag, " done one cycle"}, int'(done), 0);
    chk({tag, " idle busy"}, int'(busy), 0);
    ex0.delete();
    ex1.delete();
    ey.delete();
  endtask

  task automatic exp_s1;
    o(100, 101); o(101, 100); o(99, 100); o(100, 101);
    o(100, 99); o(99, 100); o(101, 100); o(100, 99);
  endtask

  task automatic exp_s2;
    o(320, 243); o(323, 240); o(317, 240); o(320, 243); o(320, 237); o(317, 240); o(323, 240); o(320, 237);
    o(321, 243); o(323, 241); o(317, 241); o(319, 243); o(319, 237); o(317, 239); o(323, 239); o(321, 237);
    o(322, 242); o(322, 242); o(318, 242); o(318, 242); o(318, 238); o(318, 238); o(322, 238); o(322, 238);
  endtask

  initial begin
    #1;
    chk("rst valid", int'(px_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst x0", int'(px_x0), 0);
    chk("rst y", int'(px_y), 0);
    #11 n_rst = 1;

    exp_s1();
    run("s1", 100, 100, 1, 0);
    chk("s1 latency", first_v, 2);

    exp_s2();
    run("s2", 320, 240, 3, 0);

    s(320, 320, 243); s(317, 323, 240); s(317, 323, 240); s(320, 320, 237);
    s(319, 321, 243); s(317, 323, 241); s(317, 323, 239); s(319, 321, 237);
    s(318, 322, 242); s(318, 322, 242); s(318, 322, 238); s(318, 322, 238);
    run("s3", 320, 240, 3, 1);

    o(0, 2); o(2, 0); o(0, 2); o(2, 0); o(1, 2); o(2, 1);
    run("s4o", 0, 0, 2, 0);
    s(0, 0, 2); s(0, 2, 0); s(0, 2, 0); s(0, 1, 2); s(0, 2, 1);
    run("s4f", 0, 0, 2, 1);

    for (int i = 0; i < 8; i++) o(50, 60);
    run("r0", 50, 60, 0, 0);

    run("off", 1000, 100, 5, 0);

    rnd_en = 1;
    exp_s2();
    run("bp", 320, 240, 3, 0);
    rnd_en = 0;
    chk("bp stalls seen", int'(stalls > 0), 1);

    @(posedge clk);
    #1 start = 1; abort = 1;
    @(posedge clk);
    #1 start = 0; abort = 0;
    @(negedge clk);
    chk("start+abort busy", int'(busy), 0);

    ready_fix = 0;
    d0 = done_cnt;
    @(posedge clk);
    #1 cx = 320; cy = 240; radius = 3; fill = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int w = 0; w < 50 && !px_valid; w++) @(negedge clk);
    chk("ab valid seen", int'(px_valid), 1);
    repeat (3) @(negedge clk);
    chk("ab stall x0", int'(px_x0), 320);
    chk("ab stall y", int'(px_y), 243);
    @(posedge clk);
    #1 abort = 1; ready_fix = 1; base = gx0.size();
    @(negedge clk);
    chk("ab prio valid", int'(px_valid), 0);
    @(posedge clk);
    #1 abort = 0;
    @(negedge clk);
    chk("ab busy", int'(busy), 0);
    chk("ab valid", int'(px_valid), 0);
    chk("ab no xfer", gx0.size() - base, 0);
    repeat (40) @(negedge clk);
    chk("ab no done", done_cnt - d0, 0);

    d0 = done_cnt;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (6) @(posedge clk);
    #2 n_rst = 0;
    #1;
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst valid", int'(px_valid), 0);
    chk("mid rst x0", int'(px_x0), 0);
    chk("mid rst y", int'(px_y), 0);
    @(posedge clk);
    @(posedge clk);
    #2 n_rst = 1;
    chk("mid rst no done", done_cnt - d0, 0);
    exp_s1();
    run("s6", 100, 100, 1, 0);

    chk("stable while stalled", stab_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/circle_raster.md
Name: circle_raster

Overview:
- Parametrised second-generation Bresenham circle rasteriser.
- Accepts centre, radius and mode (outline or filled). Streams pixel/span write requests to the framebuffer writer over a valid/ready handshake; no separate stall input.
- Adds filled-circle spans, screen clipping, an abort input, and a busy/done pulse.
- Sits between the primitive decoder and the framebuffer address generator.

Parameters:
- XW, 10, x-coordinate width (unsigned screen coordinate).
- YW, 9, y-coordinate width.
- RW, 10, radius width (unsigned).
- SCR_W, 640, visible width; valid x range is 0..SCR_W-1.
- SCR_H, 480, visible height; valid y range is 0..SCR_H-1.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE with no done pulse
- fill  in  1  0 = outline points, 1 = filled horizontal spans; latched at start
- cx  in  XW  centre x; latched at start
- cy  in  YW  centre y; latched at start
- radius  in  RW  radius; latched at start
- px_valid  out  1  output beat valid
- px_ready  in  1  downstream accepts beat
- px_x0  out  XW  point x, or span left x
- px_x1  out  XW  span right x (equals px_x0 in outline mode)
- px_y  out  YW  row
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last beat transfers

Behaviour:
- Reset (async, n_rst=0):
  - FSM goes to IDLE.
  - px_valid=0, busy=0, done=0.
  - px_x0/px_x1/px_y=0.
  - Internal x, y, d cleared.
- Internal arithmetic:
  - Signed, width max(XW,YW,RW)+2 for coordinates; RW+4 for the decision variable d.
  - Clip tests use signed values, so no wrap-around before clipping.
- FSM states: IDLE, CHECK, EMIT, UPDATE, FINISH.
  - IDLE: on start=1, latch inputs; x=0, y=radius, d=3-2*radius, k=0; go to CHECK.
  - CHECK: if x<=y, go to EMIT with k=0; else go to FINISH.
  - EMIT: candidate index k runs 0..7 in outline mode and 0..3 in fill mode.
    - If the candidate is fully clipped: no beat, k advances next cycle.
    - Otherwise px_valid=1 with stable data until px_ready=1; k advances on the transfer.
    - After the last k, go to UPDATE.
  - UPDATE:
    - If d<=0: d+=4x+6.
    - Else: d+=4(x-y)+10 and y-=1.
    - Always x+=1. Then go to CHECK.
  - FINISH: done=1 for one cycle, busy=0; go to IDLE.
- Outline candidate order, for k=0..7:
  - (cx+x,cy+y), (cx+y,cy+x), (cx-y,cy+x), (cx-x,cy+y)
  - (cx-x,cy-y), (cx-y,cy-x), (cx+y,cy-x), (cx+x,cy-y)
  - A point is dropped if x<0, x>=SCR_W, y<0 or y>=SCR_H.
- Fill candidate order, for k=0..3, as spans (xl..xr, row):
  - (cx-x..cx+x, cy+y), (cx-y..cx+y, cy+x), (cx-y..cx+y, cy-x), (cx-x..cx+x, cy-y)
  - Row outside 0..SCR_H-1: span dropped.
  - xl, xr clamped to 0..SCR_W-1; span dropped if xr<0 or xl>=SCR_W.
- Duplicate beats (e.g. x==0 or x==y) are not suppressed; downstream writes are idempotent.
- Latency: start sampled at edge N; earliest px_valid is in cycle N+2.
- Handshake:
  - Transfer occurs when px_valid&&px_ready.
  - Data must not change while px_valid=1 and px_ready=0.
  - px_valid never drops without a transfer, except on abort or reset.
- abort=1 in any non-IDLE state: next state is IDLE, px_valid=0, busy=0, no done. abort has priority over px_ready in the same cycle.
- start while busy is ignored. start and abort together in IDLE: abort wins and the start is ignored.
- radius=0 is legal: outline mode emits 8 beats of (cx,cy).
- A fully off-screen circle runs the FSM without emitting any beat; done still pulses.

Test Plan:
1. cx=100, cy=100, r=1, outline, px_ready=1 -> 8 beats (100,101),(101,100),(99,100),(100,101),(100,99),(99,100),(101,100),(100,99); then done pulse; busy high for the whole run.
2. cx=320, cy=240, r=3, outline -> exactly 24 beats (3 steps; x/y pairs (0,3),(1,3),(2,2)); first beat is (320,243).
3. Same circle as scenario 2 with fill=1 -> 12 spans; first span x0=320, x1=320, y=243; second span 317..323 at y=240.
4. cx=0, cy=0, r=2, outline -> only beats with x>=0, y>=0 appear; fill mode: spans clamped to xl=0.
5. Backpressure: px_ready toggled randomly -> beat sequence identical to the px_ready=1 run; data stable while stalled; no lost or duplicated beats.
6. Abort while px_valid is pending, then n_rst pulsed low mid-run -> IDLE immediately, px_valid=0, no done; a new start afterwards runs from scratch correctly.
